// File: rtl/serial_sub.sv
// serial_sub: bit-serial borrow-ripple subtractor, diff = a - b - bin mod 2^WIDTH, LSB first.
// Latency: WIDTH cycles from operand acceptance to out_valid; one operation in flight at a time.
// Backpressure: result held stable in DONE until out_ready; in_ready is low from acceptance until IDLE returns.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             bout_q;
    logic             ovf_q;

    logic             x;
    logic             y;
    logic             d;
    logic             br_next;

    // One bit-slice of the borrow ripple, fed from the LSBs of the operand shifters.
    always_comb begin
        x       = sh_a[0];
        y       = sh_b[0];
        d       = x ^ y ^ br;
        br_next = (~x & y) | (~(x ^ y) & br);
    end

    // Handshake FSM plus operand/result shift registers; reset wins over every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sh_a   <= '0;
            sh_b   <= '0;
            diff_q <= '0;
            cnt    <= '0;
            br     <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a   <= a;
                        sh_b   <= b;
                        br     <= bin;
                        cnt    <= '0;
                        diff_q <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_a   <= {1'b0, sh_a[WIDTH-1:1]};
                    sh_b   <= {1'b0, sh_b[WIDTH-1:1]};
                    diff_q <= {d, diff_q[WIDTH-1:1]};
                    br     <= br_next;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Borrow into the MSB differs from borrow out of it => signed overflow.
                        bout_q <= br_next;
                        ovf_q  <= br ^ br_next;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = (diff_q == '0);

endmodule
